// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: merges front-end redirect requests into one next-PC
// redirect for the PC generator. Fixed priority dly > exc > res > replay > pre.
// A redirect is held until fetch accepts it. A resolved-branch mispredict is
// parked until that branch's delay slot has been fetched.
// Optional build macro: REDIRECT_STATS_EN adds per-source accept counters.
//
// state   | meaning
// IDLE    | no redirect pending
// PEND    | redirect_valid_o high, waiting for ready_i
// WAIT_DS | resolved-branch redirect parked until the delay slot is fetched
module fetch_redirect_ctrl #(
  parameter int                   VADDR_W  = 32,
  parameter logic [VADDR_W-1:0]   BOOT_VEC = 'hbfc00000,
  parameter int                   STAT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ready_i,
  input  logic               except_valid_i,
  input  logic [VADDR_W-1:0] except_vec_i,
  input  logic               dly_mispredict_i,
  input  logic [VADDR_W-1:0] dly_target_i,
  input  logic               res_mispredict_i,
  input  logic               res_taken_i,
  input  logic [VADDR_W-1:0] res_target_i,
  input  logic [VADDR_W-1:0] res_pc_i,
  input  logic               res_ds_fetched_i,
  input  logic               ds_fetch_done_i,
  input  logic               replay_valid_i,
  input  logic [VADDR_W-1:0] replay_vaddr_i,
  input  logic               pre_mispredict_i,
  input  logic [VADDR_W-1:0] pre_target_i,
  output logic               redirect_valid_o,
  output logic [VADDR_W-1:0] redirect_vaddr_o,
  output logic [2:0]         redirect_src_o,
  output logic               flush_front_o,
  output logic               busy_o,
  input  logic [2:0]         stat_sel_i,
  output logic [STAT_W-1:0]  stat_count_o
);

  typedef enum logic [1:0] {IDLE, PEND, WAIT_DS} state_e;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_DLY  = 3'd1;
  localparam logic [2:0] SRC_EXC  = 3'd2;
  localparam logic [2:0] SRC_RES  = 3'd3;
  localparam logic [2:0] SRC_RPL  = 3'd4;
  localparam logic [2:0] SRC_PRE  = 3'd5;

  state_e             state_q, state_d;
  logic [VADDR_W-1:0] vaddr_q, vaddr_d;
  logic [2:0]         src_q, src_d;

  logic [2:0]         win_src;
  logic [VADDR_W-1:0] win_addr;
  logic [VADDR_W-1:0] res_addr;
  logic               take;

  // Not-taken path skips the branch and its delay slot; wraps at 2^VADDR_W.
  assign res_addr = res_taken_i ? res_target_i : res_pc_i + VADDR_W'(8);

  // Fixed-priority pick; later assignments override, so dly ends up on top.
  always_comb begin
    win_src  = SRC_NONE;
    win_addr = '0;
    if (pre_mispredict_i) begin win_src = SRC_PRE; win_addr = pre_target_i;   end
    if (replay_valid_i)   begin win_src = SRC_RPL; win_addr = replay_vaddr_i; end
    if (res_mispredict_i) begin win_src = SRC_RES; win_addr = res_addr;       end
    if (except_valid_i)   begin win_src = SRC_EXC; win_addr = except_vec_i;   end
    if (dly_mispredict_i) begin win_src = SRC_DLY; win_addr = dly_target_i;   end
  end

  // Next-state logic: decide whether the winning request is taken this cycle.
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    src_d   = src_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: take = (win_src != SRC_NONE);
      PEND: begin
        if (ready_i) begin
          // Accept completes; a same-cycle request is handled as from IDLE.
          take = (win_src != SRC_NONE);
          if (!take) begin
            state_d = IDLE;
            src_d   = SRC_NONE;
          end
        end else begin
          take = (win_src != SRC_NONE) && (win_src < src_q);
        end
      end
      WAIT_DS: begin
        if (win_src == SRC_DLY || win_src == SRC_EXC) begin
          take = 1'b1;
        end else if (ds_fetch_done_i) begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
        src_d   = SRC_NONE;
      end
    endcase
    if (take) begin
      vaddr_d = win_addr;
      src_d   = win_src;
      state_d = (win_src == SRC_RES && !res_ds_fetched_i) ? WAIT_DS : PEND;
    end
  end

  // State and held redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vaddr_q <= BOOT_VEC;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      src_q   <= src_d;
    end
  end

  assign redirect_valid_o = (state_q == PEND);
  assign redirect_vaddr_o = vaddr_q;
  assign redirect_src_o   = src_q;
  assign flush_front_o    = redirect_valid_o & ready_i;
  assign busy_o           = (state_q != IDLE);

`ifdef REDIRECT_STATS_EN
  logic [STAT_W-1:0] cnt_q [1:5];

  // Saturating per-source count of accepted redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i <= 5; i++) cnt_q[i] <= '0;
    end else if (flush_front_o && src_q >= SRC_DLY && src_q <= SRC_PRE) begin
      if (cnt_q[src_q] != '1) cnt_q[src_q] <= cnt_q[src_q] + STAT_W'(1);
    end
  end

  // Counter readback; unused selects read zero.
  always_comb begin
    stat_count_o = '0;
    if (stat_sel_i >= SRC_DLY && stat_sel_i <= SRC_PRE) stat_count_o = cnt_q[stat_sel_i];
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel_i;
  assign stat_count_o    = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] BOOT = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst, ready, except_valid, dly_mispredict, res_mispredict, res_taken;
  logic        res_ds_fetched, ds_fetch_done, replay_valid, pre_mispredict;
  logic [31:0] except_vec, dly_target, res_target, res_pc, replay_vaddr, pre_target;
  logic        redirect_valid, flush_front, busy;
  logic [31:0] redirect_vaddr, stat_count;
  logic [2:0]  redirect_src, stat_sel;

  int ntests = 0;
  int nfail  = 0;

  // reference model state
  bit              m_pend, m_wait;
  int              m_src;
  logic [31:0]     m_addr;
  longint unsigned m_cnt [0:7];

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ready_i(ready),
    .except_valid_i(except_valid), .except_vec_i(except_vec),
    .dly_mispredict_i(dly_mispredict), .dly_target_i(dly_target),
    .res_mispredict_i(res_mispredict), .res_taken_i(res_taken),
    .res_target_i(res_target), .res_pc_i(res_pc), .res_ds_fetched_i(res_ds_fetched),
    .ds_fetch_done_i(ds_fetch_done),
    .replay_valid_i(replay_valid), .replay_vaddr_i(replay_vaddr),
    .pre_mispredict_i(pre_mispredict), .pre_target_i(pre_target),
    .redirect_valid_o(redirect_valid), .redirect_vaddr_o(redirect_vaddr),
    .redirect_src_o(redirect_src), .flush_front_o(flush_front), .busy_o(busy),
    .stat_sel_i(stat_sel), .stat_count_o(stat_count)
  );

  task automatic clear_inputs();
    rst = 0; ready = 0; except_valid = 0; dly_mispredict = 0; res_mispredict = 0;
    res_taken = 0; res_ds_fetched = 0; ds_fetch_done = 0; replay_valid = 0;
    pre_mispredict = 0; except_vec = 0; dly_target = 0; res_target = 0; res_pc = 0;
    replay_vaddr = 0; pre_target = 0; stat_sel = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level model: one pending redirect or one parked branch at most.
  task automatic model_step();
    int w;
    logic [31:0] wa;
    bit acc, tk;
    if (rst) begin
      m_pend = 0; m_wait = 0; m_src = 0; m_addr = BOOT;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      return;
    end
    w = 0; wa = 0;
    if (dly_mispredict)      begin w = 1; wa = dly_target; end
    else if (except_valid)   begin w = 2; wa = except_vec; end
    else if (res_mispredict) begin w = 3; wa = res_taken ? res_target : res_pc + 32'd8; end
    else if (replay_valid)   begin w = 4; wa = replay_vaddr; end
    else if (pre_mispredict) begin w = 5; wa = pre_target; end
    acc = m_pend && ready;
    if (acc && m_cnt[m_src] < 64'hffffffff) m_cnt[m_src]++;
    tk = 0;
    if (m_wait) begin
      if (w == 1 || w == 2) tk = 1;
      else if (ds_fetch_done) begin m_wait = 0; m_pend = 1; end
    end else if (m_pend && !acc) begin
      tk = (w != 0 && w < m_src);
    end else begin
      tk = (w != 0);
      if (!tk) begin m_pend = 0; m_src = 0; end
    end
    if (tk) begin
      m_src = w; m_addr = wa;
      if (w == 3 && !res_ds_fetched) begin m_wait = 1; m_pend = 0; end
      else begin m_wait = 0; m_pend = 1; end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; ready = 1;
    tick(); tick();
    ntests++;
    if (redirect_valid !== 1'b0 || redirect_vaddr !== BOOT || redirect_src !== 3'd0 ||
        busy !== 1'b0 || flush_front !== 1'b0) begin
      nfail++;
      $display("FAIL reset: valid=%b vaddr=%h src=%0d busy=%b flush=%b, want 0 %h 0 0 0",
               redirect_valid, redirect_vaddr, redirect_src, busy, flush_front, BOOT);
    end
    ntests++;
    if (stat_count !== 32'd0) begin
      nfail++; $display("FAIL reset_stat: got %0d want 0", stat_count);
    end
    rst = 0;
  endtask

  task automatic test_single();
    clear_inputs();
    replay_valid = 1; replay_vaddr = 32'h80001000; ready = 1;
    tick();
    replay_valid = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'h80001000 || redirect_src !== 3'd4 ||
        flush_front !== 1'b1) begin
      nfail++;
      $display("FAIL single: valid=%b vaddr=%h src=%0d flush=%b, want 1 80001000 4 1",
               redirect_valid, redirect_vaddr, redirect_src, flush_front);
    end
    tick();
    ntests++;
    if (redirect_valid !== 1'b0 || flush_front !== 1'b0) begin
      nfail++;
      $display("FAIL single_done: valid=%b flush=%b, want 0 0", redirect_valid, flush_front);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    except_valid = 1; except_vec = 32'hbfc00380;
    pre_mispredict = 1; pre_target = 32'h80002000;
    tick();
    except_valid = 0; pre_mispredict = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'hbfc00380 || redirect_src !== 3'd2) begin
      nfail++;
      $display("FAIL priority: valid=%b vaddr=%h src=%0d, want 1 bfc00380 2",
               redirect_valid, redirect_vaddr, redirect_src);
    end
    ready = 1;
    tick();
    ntests++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL priority_drop: valid=%b busy=%b, want 0 0", redirect_valid, busy);
    end
  endtask

  task automatic test_ds_wait();
    clear_inputs();
    res_mispredict = 1; res_taken = 0; res_pc = 32'h80000010; res_ds_fetched = 0;
    tick();
    res_mispredict = 0;
    for (int i = 0; i < 3; i++) begin
      ntests++;
      if (busy !== 1'b1 || redirect_valid !== 1'b0) begin
        nfail++;
        $display("FAIL ds_wait[%0d]: busy=%b valid=%b, want 1 0", i, busy, redirect_valid);
      end
      if (i == 2) ds_fetch_done = 1;
      tick();
    end
    ds_fetch_done = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'h80000018 || redirect_src !== 3'd3) begin
      nfail++;
      $display("FAIL ds_release: valid=%b vaddr=%h src=%0d, want 1 80000018 3",
               redirect_valid, redirect_vaddr, redirect_src);
    end
    ready = 1;
    tick();
    ready = 0;
  endtask

  task automatic test_wrap_override();
    clear_inputs();
    res_mispredict = 1; res_pc = 32'hfffffffc;
    tick();
    res_mispredict = 0; ds_fetch_done = 1;
    tick();
    ds_fetch_done = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'h00000004 || redirect_src !== 3'd3) begin
      nfail++;
      $display("FAIL wrap: valid=%b vaddr=%h src=%0d, want 1 00000004 3",
               redirect_valid, redirect_vaddr, redirect_src);
    end
    ready = 1; tick(); ready = 0;
    res_mispredict = 1; res_pc = 32'hfffffffc;
    tick();
    res_mispredict = 0; except_valid = 1; except_vec = 32'hbfc00200;
    replay_valid = 1; replay_vaddr = 32'h12345678;
    tick();
    except_valid = 0; replay_valid = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'hbfc00200 || redirect_src !== 3'd2) begin
      nfail++;
      $display("FAIL override: valid=%b vaddr=%h src=%0d, want 1 bfc00200 2",
               redirect_valid, redirect_vaddr, redirect_src);
    end
    ready = 1; tick(); ready = 0;
  endtask

  task automatic test_hold_replace();
    int flushes;
    clear_inputs();
    pre_mispredict = 1; pre_target = 32'h80003000;
    tick();
    pre_mispredict = 0;
    for (int i = 0; i < 5; i++) begin
      ntests++;
      if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'h80003000 || redirect_src !== 3'd5 ||
          flush_front !== 1'b0) begin
        nfail++;
        $display("FAIL hold[%0d]: valid=%b vaddr=%h src=%0d flush=%b, want 1 80003000 5 0",
                 i, redirect_valid, redirect_vaddr, redirect_src, flush_front);
      end
      tick();
    end
    replay_valid = 1; replay_vaddr = 32'h80004000;
    tick();
    replay_valid = 0; pre_mispredict = 1; pre_target = 32'h80005000;
    tick();
    pre_mispredict = 0;
    ntests++;
    if (redirect_valid !== 1'b1 || redirect_vaddr !== 32'h80004000 || redirect_src !== 3'd4) begin
      nfail++;
      $display("FAIL replace: valid=%b vaddr=%h src=%0d, want 1 80004000 4",
               redirect_valid, redirect_vaddr, redirect_src);
    end
    ready = 1;
    flushes = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (flush_front === 1'b1) flushes++;
      tick();
    end
    ntests++;
    if (flushes != 1) begin
      nfail++; $display("FAIL flush_once: got %0d pulses want 1", flushes);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    pre_mispredict = 1; pre_target = 32'h80006000;
    tick();
    pre_mispredict = 0; rst = 1;
    tick();
    rst = 0;
    ntests++;
    if (redirect_valid !== 1'b0 || redirect_vaddr !== BOOT || redirect_src !== 3'd0) begin
      nfail++;
      $display("FAIL reset_mid: valid=%b vaddr=%h src=%0d, want 0 %h 0",
               redirect_valid, redirect_vaddr, redirect_src, BOOT);
    end
    for (int k = 0; k < 2; k++) begin
      replay_valid = 1; replay_vaddr = 32'h80007000; ready = 1;
      tick();
      replay_valid = 0;
      tick();
    end
    stat_sel = 4; #1;
`ifdef REDIRECT_STATS_EN
    ntests++;
    if (stat_count !== 32'd2) begin
      nfail++; $display("FAIL stat_replay: got %0d want 2", stat_count);
    end
`else
    ntests++;
    if (stat_count !== 32'd0) begin
      nfail++; $display("FAIL stat_off: got %0d want 0", stat_count);
    end
`endif
    stat_sel = 0; #1;
    ntests++;
    if (stat_count !== 32'd0) begin
      nfail++; $display("FAIL stat_sel0: got %0d want 0", stat_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] want_cnt;
    clear_inputs();
    rst = 1;
    model_step();
    tick();
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      ready          = $urandom_range(0, 1);
      dly_mispredict = ($urandom_range(0, 9) == 0);
      except_valid   = ($urandom_range(0, 7) == 0);
      res_mispredict = ($urandom_range(0, 3) == 0);
      replay_valid   = ($urandom_range(0, 3) == 0);
      pre_mispredict = ($urandom_range(0, 3) == 0);
      ds_fetch_done  = ($urandom_range(0, 3) == 0);
      res_taken      = $urandom_range(0, 1);
      res_ds_fetched = $urandom_range(0, 1);
      dly_target     = $urandom;
      except_vec     = $urandom;
      res_target     = $urandom;
      res_pc         = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | ($urandom & 32'hc)) : $urandom;
      replay_vaddr   = $urandom;
      pre_target     = $urandom;
      stat_sel       = 3'($urandom_range(0, 7));
      #1;
      ntests++;
      if (flush_front !== (m_pend && ready)) begin
        nfail++;
        $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush_front, m_pend && ready);
      end
`ifdef REDIRECT_STATS_EN
      want_cnt = (stat_sel >= 1 && stat_sel <= 5) ? 32'(m_cnt[stat_sel]) : 32'd0;
`else
      want_cnt = 32'd0;
`endif
      ntests++;
      if (stat_count !== want_cnt) begin
        nfail++;
        $display("FAIL rnd_stat[%0d]: sel=%0d got %0d want %0d", n, stat_sel, stat_count, want_cnt);
      end
      model_step();
      tick();
      ntests++;
      if (redirect_valid !== m_pend || busy !== (m_pend || m_wait) ||
          (m_pend && (redirect_vaddr !== m_addr || redirect_src !== 3'(m_src)))) begin
        nfail++;
        $display("FAIL rnd_out[%0d]: valid=%b busy=%b vaddr=%h src=%0d want %b %b %h %0d",
                 n, redirect_valid, busy, redirect_vaddr, redirect_src,
                 m_pend, m_pend || m_wait, m_addr, m_src);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_priority();
    test_ds_wait();
    test_wrap_override();
    test_hold_replace();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences all front-end redirect requests into the single next-PC redirect consumed by the PC generator. It arbitrates simultaneous sources by fixed priority and latches a redirect until the fetch stage accepts it. It also holds a branch-mispredict redirect until that branch's delay slot has been fetched. Sits between the commit/decode/branch units and the fetch PC logic.

Parameters:
VADDR_W, 32, virtual address width
BOOT_VEC, 32'hbfc00000, redirect_vaddr value after reset
STAT_W, 32, width of each statistics counter (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ready  in  1  fetch accepts a redirect this cycle
except_valid  in  1  exception redirect request
except_vec  in  VADDR_W  exception target
dly_mispredict  in  1  delayed-branch mispredict; delay slot already fetched
dly_target  in  VADDR_W  delayed-branch redirect address
res_mispredict  in  1  resolved-branch mispredict
res_taken  in  1  resolved branch actual direction
res_target  in  VADDR_W  resolved taken target
res_pc  in  VADDR_W  resolved branch PC
res_ds_fetched  in  1  delay slot of the resolved branch already fetched
ds_fetch_done  in  1  pulse: pending branch's delay slot now fetched
replay_valid  in  1  replay request
replay_vaddr  in  VADDR_W  replay address
pre_mispredict  in  1  presolved-branch mispredict
pre_target  in  VADDR_W  presolved target
redirect_valid  out  1  redirect pending for the PC generator
redirect_vaddr  out  VADDR_W  redirect address
redirect_src  out  3  1=dly 2=exc 3=res 4=replay 5=pre, 0=none
flush_front  out  1  one-cycle pulse when a redirect is accepted
busy  out  1  state != IDLE
stat_sel  in  3  counter select (optional feature)
stat_count  out  STAT_W  selected counter (optional feature)

Behaviour:
- Reset: state IDLE; redirect_valid=0, redirect_vaddr=BOOT_VEC, redirect_src=0, flush_front=0, busy=0, counters=0. rst mid-operation drops any pending redirect the next cycle.
- Priority, highest first: dly > exc > res > replay > pre. Rank = src code; a lower code is a higher priority.
- Resolved address: res_taken ? res_target : res_pc+8, computed modulo 2^VADDR_W (wraps).
- States: IDLE, PEND, WAIT_DS.
- IDLE: the winning request is registered. redirect_valid rises the cycle after the request (1-cycle latency) and the state moves to PEND. Exception: a winning res with res_ds_fetched=0 moves to WAIT_DS instead and stores the resolved address.
- WAIT_DS: redirect_valid=0. A ds_fetch_done pulse moves to PEND; redirect_valid=1 the next cycle with the stored address and src=3.
  - dly or exc arriving in WAIT_DS overrides the stored branch and moves to PEND.
  - replay and pre are ignored in WAIT_DS.
- PEND: redirect_valid, vaddr and src stay stable until ready=1.
  - On redirect_valid&ready: flush_front pulses that cycle; the next state is IDLE, or is re-entered if a new request arrives in that same cycle.
  - A new request of strictly higher priority than the held src replaces it in place, registered, with no intermediate IDLE.
  - An equal- or lower-priority request is dropped.
- Simultaneous accept and new request: the accept completes, and the new request is processed as if in IDLE.
- ds_fetch_done outside WAIT_DS is ignored.

Optional Feature:
REDIRECT_STATS_EN
- Defined: per-source saturating STAT_W counters, incremented on each accepted redirect (redirect_valid&ready) for that src.
  - stat_count = counter[stat_sel]; stat_sel 0, 6 and 7 read 0.
  - Counters clear on rst.
- Undefined: no counters; stat_count tied 0 and stat_sel unused.

Test Plan:
- Single source: replay_valid=1, replay_vaddr=0x80001000 at cycle 0, ready=1 -> cycle 1: redirect_valid=1, vaddr=0x80001000, src=4, flush_front=1; cycle 2: redirect_valid=0.
- Priority: exc (0xbfc00380) and pre (0x80002000) in the same cycle -> vaddr=0xbfc00380, src=2; pre dropped.
- Delay-slot wait: res_mispredict, res_taken=0, res_pc=0x80000010, res_ds_fetched=0 -> busy=1, redirect_valid=0; ds_fetch_done 3 cycles later -> next cycle vaddr=0x80000018, src=3.
- Wrap and override: res_pc=0xfffffffc, not taken -> stored 0x00000004. exc arriving in WAIT_DS -> vaddr=except_vec, src=2.
- Hold and replace: ready=0 with pre pending (0x80003000) -> output stable for 5 cycles; replay arrives -> vaddr=replay_vaddr, src=4; a later pre is dropped; ready=1 -> flush_front pulses once.
- Reset mid-PEND: rst=1 -> next cycle redirect_valid=0, vaddr=0xbfc00000, src=0. With REDIRECT_STATS_EN, after 2 accepted replays, stat_sel=4 -> stat_count=2.
